// File: rtl/cam_pixel_binarizer.sv
// ---------------------------------------------------------------------------
// cam_pixel_binarizer
//
// Captures the OV7670 8-bit parallel bus in the Clk domain. It pairs YUV422
// bytes (Y, then chroma) and thresholds Y to one bit per pixel. It then
// issues single-cycle frame-RAM write strobes with a linear row-major address.
// Frame and line framing are tracked, so only frames that start with a full
// VSYNC high->low sequence are written. Lines past V_RES and pixels past
// H_RES are dropped.
//
// Optional build macro: CAM_MIRROR_EN
//   defined   -> write_addr = row*H_RES + (H_RES-1-col)  (horizontal mirror)
//   undefined -> write_addr = row*H_RES + col
//
// Ports
//   Clk          in   system clock, all logic on rising edge
//   Reset        in   synchronous active-high reset
//   data_cam     in   [7:0] camera data byte (asynchronous)
//   VSYNC_cam    in   frame sync, high between frames (asynchronous)
//   HREF_cam     in   line valid (asynchronous)
//   PCLK_cam     in   camera pixel clock (asynchronous, <= Clk/4)
//   write_addr   out  [18:0] frame RAM address, valid while pixel_we=1
//   pixel_out    out  binarized pixel, valid while pixel_we=1
//   pixel_we     out  one-cycle write strobe
//   frame_done   out  one-cycle pulse at the end of a complete frame
//   frame_count  out  [7:0] completed frames, wrapping
//   line_err     out  sticky odd-byte / over-long line flag, cleared at frame start
// ---------------------------------------------------------------------------
module cam_pixel_binarizer #(
    parameter int         H_RES  = 640,
    parameter int         V_RES  = 480,
    parameter logic [7:0] THRESH = 8'h80
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  data_cam,
    input  logic        VSYNC_cam,
    input  logic        HREF_cam,
    input  logic        PCLK_cam,
    output logic [18:0] write_addr,
    output logic        pixel_out,
    output logic        pixel_we,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        line_err
);

    localparam int ADDR_W = 19;
    localparam int COL_W  = $clog2(H_RES + 1);
    localparam int ROW_W  = $clog2(V_RES + 1);

    localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_RES);
    localparam logic [ROW_W-1:0]  V_MAX  = ROW_W'(V_RES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);
`ifdef CAM_MIRROR_EN
    localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_RES - 1);
`endif

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;

    // Input synchronisers: bit 1 is the synced value, bit 2 its previous value.
    logic [2:0] pclk_q;
    logic [2:0] vsync_q;
    logic [1:0] href_q;
    logic [7:0] data_s1_q, data_s2_q;

    // Edge-detect stage: byte strobe plus HREF/data aligned to it.
    logic       rise_q;
    logic       href_stg_q;
    logic [7:0] data_stg_q;

    state_t            state_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;   // row*H_RES, kept incrementally
    logic              phase_q, phase_d;
    logic [7:0]        y_q, y_d;
    logic              err_d, we_d, pix_d;
    logic [ADDR_W-1:0] addr_d;

    logic byte_valid, href_fall, vsync_rise, vsync_fall;

    always_ff @(posedge Clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            pclk_q     <= '0;
            vsync_q    <= '0;
            href_q     <= '0;
            data_s1_q  <= '0;
            data_s2_q  <= '0;
            rise_q     <= 1'b0;
            href_stg_q <= 1'b0;
            data_stg_q <= '0;
        end else begin
            pclk_q     <= {pclk_q[1:0], PCLK_cam};
            vsync_q    <= {vsync_q[1:0], VSYNC_cam};
            href_q     <= {href_q[0], HREF_cam};
            data_s1_q  <= data_cam;
            data_s2_q  <= data_s1_q;
            rise_q     <= pclk_q[1] & ~pclk_q[2];
            href_stg_q <= href_q[1];
            data_stg_q <= data_s2_q;
        end
    end

    assign byte_valid = rise_q & href_stg_q;
    // href_q[1] is the value href_stg_q takes next, so the fall is seen in the
    // same cycle as a coinciding final byte, letting the byte go first.
    assign href_fall  = href_stg_q & ~href_q[1];
    assign vsync_rise = vsync_q[1] & ~vsync_q[2];
    assign vsync_fall = ~vsync_q[1] & vsync_q[2];

    // Byte/line sequencing for one ACTIVE cycle: byte first, then line end.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        phase_d = phase_q;
        y_d     = y_q;
        err_d   = line_err;
        we_d    = 1'b0;
        addr_d  = write_addr;
        pix_d   = pixel_out;

        if (byte_valid) begin
            if (!phase_q) begin
                y_d     = data_stg_q;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                // Rows past the frame are silently dropped; col stays 0 there.
                if (row_q < V_MAX) begin
                    if (col_q < H_MAX) begin
                        we_d  = 1'b1;
                        pix_d = (y_q >= THRESH);
`ifdef CAM_MIRROR_EN
                        addr_d = base_q + H_LAST - ADDR_W'(col_q);
`else
                        addr_d = base_q + ADDR_W'(col_q);
`endif
                        col_d = col_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end

        if (href_fall) begin
            if (phase_d) begin
                err_d = 1'b1;
            end
            if (col_d != '0 && row_q < V_MAX) begin
                row_d  = row_q + 1'b1;
                base_d = base_q + H_STEP;
            end
            col_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            base_q      <= '0;
            phase_q     <= 1'b0;
            y_q         <= '0;
            write_addr  <= '0;
            pixel_out   <= 1'b0;
            pixel_we    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_err    <= 1'b0;
        end else begin
            pixel_we   <= 1'b0;
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vsync_q[1]) state_q <= VBLANK;
                end
                VBLANK: begin
                    if (vsync_fall) begin
                        col_q    <= '0;
                        row_q    <= '0;
                        base_q   <= '0;
                        phase_q  <= 1'b0;
                        line_err <= 1'b0;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vsync_rise) begin
                        state_q <= VBLANK;
                        // Only a frame that reached the last row counts.
                        if (row_q == V_MAX) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end else begin
                        col_q      <= col_d;
                        row_q      <= row_d;
                        base_q     <= base_d;
                        phase_q    <= phase_d;
                        y_q        <= y_d;
                        line_err   <= err_d;
                        pixel_we   <= we_d;
                        write_addr <= addr_d;
                        pixel_out  <= pix_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
